// File: rtl/counter_7sd_if.sv
// Display-side signal bundle for counter_7sd: count controls in, segment pattern out.
// The master drives pause/reverse and observes data; the counter is the slave.
interface counter_7sd_if;
    logic       pause;
    logic       reverse;
    logic [6:0] data;

    modport master (output pause, output reverse, input data);
    modport slave  (input pause, input reverse, output data);
endinterface

// File: rtl/counter_7sd.sv
// Single-digit up/down counter with prescaler and common-cathode seven-segment decode.
// Define COUNTER7SD_HEX_EN to count 0-F instead of 0-9.
module counter_7sd #(
    parameter int unsigned DIV = 1
) (
    input  logic          clock,
    input  logic          reset,
    counter_7sd_if.slave  bus
);
    // A 1-bit prescaler is kept even for DIV=1; it simply stays at 0.
    localparam int unsigned      PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
`ifdef COUNTER7SD_HEX_EN
    localparam logic [3:0]       CNT_MAX  = 4'd15;
`else
    localparam logic [3:0]       CNT_MAX  = 4'd9;
`endif

    logic [3:0]       cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;

    function automatic logic [3:0] next_digit(input logic [3:0] d, input logic down);
        if (down)
            return (d == 4'd0) ? CNT_MAX : d - 4'd1;
        else
            return (d >= CNT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    // Segment order {g,f,e,d,c,b,a}; unreachable codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
`ifdef COUNTER7SD_HEX_EN
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
`endif
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Pause freezes both registers, so paused cycles never count toward DIV.
    always_comb begin
        tick  = 1'b0;
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (!bus.pause) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
            if (tick)
                cnt_d = next_digit(cnt_q, bus.reverse);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 4'd0;
            pre_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end

    assign bus.data = seg_decode(cnt_q);
endmodule

// File: tb/tb_counter_7sd.sv
// Scoreboard bench for counter_7sd: a DIV=1 and a DIV=3 instance share stimulus,
// expected patterns are queued per edge and checked by a negedge monitor.
module tb_counter_7sd;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    counter_7sd_if if1 ();
    counter_7sd_if if3 ();

    counter_7sd #(.DIV(1)) dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
    counter_7sd #(.DIV(3)) dut3 (.clock(clock), .reset(reset), .bus(if3.slave));

    typedef struct {
        bit         sel;
        logic [6:0] exp;
        string      name;
    } item_t;

    item_t q[$];
    item_t it;
    int    checks   = 0;
    int    failures = 0;
    logic [6:0] act;

`ifdef COUNTER7SD_HEX_EN
    localparam logic [6:0] SEG_MAX = 7'h71;
`else
    localparam logic [6:0] SEG_MAX = 7'h6F;
`endif

    // One edge of stimulus to both instances; expectation is for the selected one.
    task automatic step(input logic rs, input logic p, input logic r,
                        input logic [6:0] exp, input bit sel, input string name);
        reset       = rs;
        if1.pause   = p;
        if1.reverse = r;
        if3.pause   = p;
        if3.reverse = r;
        @(posedge clock);
        #1;
        q.push_back('{sel, exp, name});
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            it  = q.pop_front();
            act = it.sel ? if3.data : if1.data;
            checks++;
            if (act !== it.exp) begin
                failures++;
                $display("FAIL %s: data=%h required=%h", it.name, act, it.exp);
            end
        end
    end

    logic [6:0] up_seq   [11] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                  7'h07, 7'h7F, 7'h6F, 7'h3F, 7'h06};
    logic [6:0] down_seq [11] = '{7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66,
                                  7'h4F, 7'h5B, 7'h06, 7'h3F, 7'h6F};
    logic [6:0] hex_seq  [16] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                                  7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F};
    // DIV=3 run: {pause, reverse, expected}
    logic [8:0] div3_seq [24] = '{
        {2'b00, 7'h3F}, {2'b00, 7'h3F}, {2'b00, 7'h06}, {2'b00, 7'h06}, {2'b00, 7'h06},
        {2'b00, 7'h5B}, {2'b00, 7'h5B}, {2'b00, 7'h5B}, {2'b00, 7'h4F}, {2'b00, 7'h4F},
        {2'b01, 7'h4F}, {2'b01, 7'h5B},
        {2'b01, 7'h5B}, {2'b11, 7'h5B}, {2'b11, 7'h5B}, {2'b01, 7'h5B}, {2'b01, 7'h06},
        {2'b01, 7'h06}, {2'b01, 7'h06}, {2'b11, 7'h06}, {2'b01, 7'h3F},
        {2'b01, 7'h3F}, {2'b01, 7'h3F}, {2'b01, SEG_MAX}};

    initial begin
        reset = 1'b0;
        if1.pause = 1'b0; if1.reverse = 1'b0;
        if3.pause = 1'b0; if3.reverse = 1'b0;

`ifdef COUNTER7SD_HEX_EN
        step(1, 0, 0, 7'h3F, 0, "hex_reset");
        for (int i = 0; i < 16; i++) step(0, 0, 0, hex_seq[i], 0, $sformatf("hex_up%0d", i));
        step(1, 0, 0, 7'h3F, 0, "hex_reset2");
        step(0, 0, 1, 7'h71, 0, "hex_down_wrap");
`else
        step(1, 0, 0, 7'h3F, 0, "up_reset");
        for (int i = 0; i < 11; i++) step(0, 0, 0, up_seq[i], 0, $sformatf("up%0d", i));
        step(1, 0, 1, 7'h3F, 0, "down_reset");
        for (int i = 0; i < 11; i++) step(0, 0, 1, down_seq[i], 0, $sformatf("down%0d", i));
`endif

        step(1, 0, 0, 7'h3F, 0, "pause_reset");
        step(0, 0, 0, 7'h06, 0, "pause_pre1");
        step(0, 0, 0, 7'h5B, 0, "pause_pre2");
        step(0, 0, 0, 7'h4F, 0, "pause_pre3");
        step(0, 0, 0, 7'h66, 0, "pause_pre4");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 7'h66, 0, $sformatf("pause_hold%0d", i));
        step(0, 0, 0, 7'h6D, 0, "pause_release");
        step(0, 0, 0, 7'h7D, 0, "run6");
        step(0, 0, 0, 7'h07, 0, "run7");
        step(1, 1, 0, 7'h3F, 0, "reset_with_pause");
        step(0, 0, 0, 7'h06, 0, "resume1");
        step(0, 0, 0, 7'h5B, 0, "resume2");

        step(1, 0, 0, 7'h3F, 1, "div3_reset");
        for (int i = 0; i < 24; i++)
            step(0, div3_seq[i][8], div3_seq[i][7], div3_seq[i][6:0], 1,
                 $sformatf("div3_e%0d", i + 1));

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_7sd.md
# counter_7sd

Single-digit up/down counter with an integrated seven-segment decoder. A registered digit value advances once per tick, counting up or down and wrapping at the ends of its range. Pause holds the value. The segment pattern for the current digit drives a display directly. It is a leaf block placed between the system clock domain and an external common-cathode digit.

## Interface
- `DIV`, default 1: clock cycles per count tick, range 1 to 2^16. With 1, the counter advances every clock.
- `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
- `reset`, input, 1 bit: synchronous, active-high. It clears the digit and the prescaler.
- `pause`, input, 1 bit: when high, the digit and the prescaler hold their values.
- `reverse`, input, 1 bit: 0 counts up, 1 counts down.
- `data`, output, 7 bits: segment pattern, active-high. Bit order is {g,f,e,d,c,b,a} with `a` = bit 0.

## Operation
- State:
  - 4-bit digit register `cnt`.
  - Prescaler register `pre`, sized to hold DIV-1.
- Priority on each rising edge: reset, then pause, then count.
  - `reset`=1: `cnt`←0 and `pre`←0, regardless of `pause` and `reverse`.
  - `pause`=1: `cnt` and `pre` hold.
  - Otherwise, if `pre`==DIV-1, then `pre`←0 and a tick occurs. If not, `pre`←`pre`+1.
- On a tick:
  - `reverse`=0: `cnt`←`cnt`+1. MAX wraps to 0.
  - `reverse`=1: `cnt`←`cnt`−1. 0 wraps to MAX.
- MAX is 9, or 15 when the hex option is compiled in. `cnt` never holds a value above MAX.
- `reverse` is sampled only at the tick edge. Toggling it between ticks has no other effect.
- `data` is a combinational decode of `cnt`, in hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - Hex option only: A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other value decodes to 00 (blank). This is unreachable in normal operation.
- No other outputs and no status flags.

## Timing
- Reset value: `cnt`=0, so `data`=7'h3F.
  - This holds from the first rising edge with `reset`=1.
  - Before the first reset, `data` is undefined.
- Latency:
  - `data` reflects the new `cnt` in the same cycle as the edge that updates it. There is no added pipeline stage.
  - With DIV=1, the first count occurs on the first edge after `reset` deasserts. Up-count from reset shows 1 after that edge.
- Tick period: DIV unpaused clock cycles. Paused cycles do not count toward DIV.
- Reset mid-count, including mid-prescale: everything restarts from 0. The next tick comes DIV unpaused cycles after `reset` deasserts.
- Simultaneous `reset` and `pause`: reset wins.
- Simultaneous `pause` and a would-be tick: no tick. The tick happens on the first unpaused edge.
- Wrap-around completes in one tick with no intermediate value: up 9→0 and down 0→9 (F→0 and 0→F in hex mode).

## Configuration
- `COUNTER7SD_HEX_EN`
  - Defined: MAX=15, the digit sequence is 0–F, and decode covers A–F as listed.
  - Undefined (default): decimal counter, MAX=9. Values 10–15 are never produced, and their decode is blank.

## Test plan
- Reset, then up-count with DIV=1, `pause`=0, `reverse`=0, run 12 cycles.
  - Required `data`: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 3F, 06.
- Reset, then down-count with `reverse`=1 held, run 12 cycles.
  - Required `data`: 3F, 6F, 7F, 07, 7D, 6D, 66, 4F, 5B, 06, 3F, 6F. This checks the 0→9 wrap.
- Pause: count to 4 (`data`=66), then hold `pause`=1 for 5 cycles.
  - `data` stays 66 for all 5 cycles.
  - After release, the next edge gives 6D.
- Reset mid-run with `pause` high: at digit 7, assert `reset`=1 for 1 cycle together with `pause`=1.
  - `data`=3F after that edge.
  - Counting resumes from 0.
- Prescaler with DIV=3: each digit persists for exactly 3 cycles.
  - Flip `reverse` 1 cycle before a tick; the direction changes at that tick.
  - Pause in mid-prescale; the period extends by exactly the number of paused cycles.
- Hex mode with `COUNTER7SD_HEX_EN` defined, up-count 17 cycles.
  - Sequence runs 0–F (…,79,71), then 3F.
  - Down from 0 gives 71.
